// File: rtl/timeout_monitor_mc.sv
// Multi-channel timeout/watchdog monitor: shared tick prescaler, per-channel
// IDLE/COUNT/EXPIRED machines with auto-restart or sticky expiry, counter readback.
module timeout_monitor_mc #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int PRE_W = 8,
  parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic [N_CH-1:0]  kick,
  input  logic [N_CH-1:0]  clr,
  input  logic [N_CH-1:0]  sticky,
  input  logic [CNT_W-1:0] time_limit,
  input  logic [PRE_W-1:0] prescale,
  output logic [N_CH-1:0]  timeout_pulse,
  output logic [N_CH-1:0]  timeout_flag,
  output logic             any_timeout,
  input  logic [SEL_W-1:0] cnt_sel,
  output logic [CNT_W-1:0] cnt_value
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COUNT   = 2'd1;
  localparam logic [1:0] ST_EXPIRED = 2'd2;

  localparam logic [SEL_W:0] N_CH_L = (SEL_W + 1)'(N_CH);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [CNT_W-1:0] count_arr [N_CH];

  // Using >= rather than == forces a tick when prescale is lowered below pre_cnt.
  assign tick = (pre_cnt >= prescale);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic             pulse_r;
    logic             flag_r;

    always_ff @(posedge clk) begin
      if (rst || !en[i]) begin
        state   <= ST_IDLE;
        count   <= '0;
        pulse_r <= 1'b0;
        flag_r  <= 1'b0;
      end else begin
        pulse_r <= 1'b0;
        case (state)
          ST_IDLE: begin
            state  <= ST_COUNT;
            count  <= '0;
            flag_r <= 1'b0;
          end
          ST_COUNT: begin
            flag_r <= 1'b0;
            if (kick[i] || clr[i]) begin
              count <= '0;
            end else if (count >= time_limit) begin
              state   <= ST_EXPIRED;
              count   <= '0;
              pulse_r <= 1'b1;
              flag_r  <= 1'b1;
            end else if (tick) begin
              count <= count + CNT_W'(1);
            end
          end
          ST_EXPIRED: begin
            // Auto mode leaves after one cycle; sticky mode waits for clr.
            if (!sticky[i] || clr[i]) begin
              state  <= ST_COUNT;
              count  <= '0;
              flag_r <= 1'b0;
            end
          end
          default: begin
            state  <= ST_IDLE;
            count  <= '0;
            flag_r <= 1'b0;
          end
        endcase
      end
    end

    assign count_arr[i]     = count;
    assign timeout_pulse[i] = pulse_r;
    assign timeout_flag[i]  = flag_r;
  end

  assign any_timeout = |timeout_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_value <= '0;
    end else if ({1'b0, cnt_sel} < N_CH_L) begin
      cnt_value <= count_arr[cnt_sel];
    end else begin
      cnt_value <= '0;
    end
  end

endmodule
